nvdla_ram_fifo_ctrl_128x512: RTL

NVDLA_RAM_FIFO_CTRL_128X512 -- requirements
Module: nvdla_ram_fifo_ctrl_128x512

---
 rtl/nvdla_ram_fifo_pkg.sv | 23 ++
 rtl/nvdla_ram_fifo_skid.sv | 67 ++++++
 rtl/nvdla_ram_fifo_ctrl_128x512.sv | 92 +++++++++
 3 files changed

// File: rtl/nvdla_ram_fifo_pkg.sv
// Shared constants and output-buffer state encoding for the RAM-backed FIFO controller.
package nvdla_ram_fifo_pkg;

  localparam int FIFO_DEPTH = 128;
  localparam int FIFO_AW    = 7;
  localparam int FIFO_DW    = 512;
  localparam int FIFO_CW    = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_st_e;

  function automatic logic [1:0] st_occ(input skid_st_e s);
    case (s)
      ONE:     return 2'd1;
      TWO:     return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/nvdla_ram_fifo_skid.sv
// Two-entry output buffer fed by RAM read captures; entry 0 is always the oldest.
module nvdla_ram_fifo_skid
  import nvdla_ram_fifo_pkg::*;
#(
  parameter int DW = FIFO_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cap_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  output logic          vld_o,
  output logic [DW-1:0] dout_o,
  output logic [1:0]    occ_o
);

  skid_st_e      st_q, st_d;
  logic [DW-1:0] e0_q, e0_d, e1_q, e1_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= EMPTY;
    else        st_q <= st_d;
  end

  // Payload needs no reset: it is only observed while vld_o is high.
  always_ff @(posedge clk) begin
    e0_q <= e0_d;
    e1_q <= e1_d;
  end

  always_comb begin
    st_d = st_q;
    e0_d = e0_q;
    e1_d = e1_q;
    case (st_q)
      EMPTY: begin
        if (cap_i) begin
          st_d = ONE;
          e0_d = din_i;
        end
      end
      ONE: begin
        if (cap_i && pop_i) begin
          e0_d = din_i;
        end else if (cap_i) begin
          st_d = TWO;
          e1_d = din_i;
        end else if (pop_i) begin
          st_d = EMPTY;
        end
      end
      TWO: begin
        if (pop_i) begin
          e0_d = e1_q;
          if (cap_i) e1_d = din_i;
          else       st_d = ONE;
        end
      end
      default: st_d = EMPTY;
    endcase
  end

  assign vld_o  = (st_q != EMPTY);
  assign dout_o = e0_q;
  assign occ_o  = st_occ(st_q);

endmodule

// File: rtl/nvdla_ram_fifo_ctrl_128x512.sv
// FIFO controller over an external 1R1W RAM with a registered-address read and a
// two-entry output buffer; tracks RAM slots, issue credits and total occupancy.
module nvdla_ram_fifo_ctrl_128x512
  import nvdla_ram_fifo_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int DW    = FIFO_DW
) (
  input  logic               nvdla_core_clk,
  input  logic               nvdla_core_rstn,
  input  logic               wr_pvld,
  output logic               wr_prdy,
  input  logic [DW-1:0]      wr_pd,
  output logic               rd_pvld,
  input  logic               rd_prdy,
  output logic [DW-1:0]      rd_pd,
  output logic               ram_we,
  output logic [FIFO_AW-1:0] ram_wa,
  output logic [DW-1:0]      ram_di,
  output logic               ram_re,
  output logic [FIFO_AW-1:0] ram_ra,
  input  logic [DW-1:0]      ram_dout,
  output logic [FIFO_CW-1:0] fifo_count
);

  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_CW-1:0] ram_used_q, ram_used_d;
  logic [FIFO_CW-1:0] ram_avail_q, ram_avail_d;
  logic [FIFO_CW-1:0] cnt_q, cnt_d;
  logic               inflight_q, inflight_d;
  logic               push, pop, issue, cap;
  logic [1:0]         occ;

  // Ready is a pure function of registered state; the reset term keeps it low
  // while reset is held.
  assign wr_prdy = nvdla_core_rstn & (ram_used_q < FIFO_CW'(DEPTH));
  assign push    = wr_pvld & wr_prdy;
  assign pop     = rd_pvld & rd_prdy;
  assign cap     = inflight_q;

  // A read may only be issued if its data is guaranteed a buffer slot on capture.
  assign issue = (ram_avail_q != '0) &&
                 ((occ + {1'b0, inflight_q}) < (2'd2 + {1'b0, pop}));

  assign ram_we     = push;
  assign ram_wa     = wr_ptr_q;
  assign ram_di     = wr_pd;
  assign ram_re     = issue;
  assign ram_ra     = rd_ptr_q;
  assign fifo_count = cnt_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == FIFO_AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (issue) rd_ptr_d = (rd_ptr_q == FIFO_AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    ram_used_d  = ram_used_q + FIFO_CW'(push) - FIFO_CW'(cap);
    ram_avail_d = ram_avail_q + FIFO_CW'(push) - FIFO_CW'(issue);
    cnt_d       = cnt_q + FIFO_CW'(push) - FIFO_CW'(pop);
    inflight_d  = issue;
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_used_q  <= '0;
      ram_avail_q <= '0;
      cnt_q       <= '0;
      inflight_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_used_q  <= ram_used_d;
      ram_avail_q <= ram_avail_d;
      cnt_q       <= cnt_d;
      inflight_q  <= inflight_d;
    end
  end

  nvdla_ram_fifo_skid #(.DW(DW)) u_skid (
    .clk    (nvdla_core_clk),
    .rst_n  (nvdla_core_rstn),
    .cap_i  (cap),
    .din_i  (ram_dout),
    .pop_i  (pop),
    .vld_o  (rd_pvld),
    .dout_o (rd_pd),
    .occ_o  (occ)
  );

endmodule
